// File: rtl/ni_tx_message_scheduler.sv
// Round-robin scheduler sharing one NI flit transmitter among NUM_SRC message sources.
// Holds the grant from arbitration until the transmitter reports the last flit gone.
module ni_tx_message_scheduler #(
  parameter int NUM_SRC       = 4,
  parameter int SRC_IDX_WD    = 2,
  parameter int COUNTERFLITWD = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SRC-1:0]                 src_req,
  input  logic [NUM_SRC*COUNTERFLITWD-1:0]   src_num_flit,
  input  logic                               tx_gone,
  input  logic                               last_clock_beat,
  output logic                               send_message,
  output logic [COUNTERFLITWD-1:0]           num_flit_to_transmit,
  output logic [NUM_SRC-1:0]                 grant,
  output logic [SRC_IDX_WD-1:0]              grant_idx,
  output logic [NUM_SRC-1:0]                 src_done,
  output logic                               busy
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                     state, state_nxt;
  logic [SRC_IDX_WD-1:0]      rr_ptr, rr_ptr_nxt;
  logic [SRC_IDX_WD-1:0]      win_idx;
  logic                       win_vld;
  logic [COUNTERFLITWD-1:0]   win_flits;
  logic [NUM_SRC-1:0]         grant_nxt, src_done_nxt;
  logic [SRC_IDX_WD-1:0]      grant_idx_nxt;
  logic [COUNTERFLITWD-1:0]   num_flit_nxt;
  logic                       send_nxt;
  int                         cand;

  // Search upward from the source after the last winner, wrapping modulo NUM_SRC.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_SRC;
      if (!win_vld && src_req[cand[SRC_IDX_WD-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[SRC_IDX_WD-1:0];
      end
    end
  end

  assign win_flits = src_num_flit[win_idx*COUNTERFLITWD +: COUNTERFLITWD];

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant;
    grant_idx_nxt = grant_idx;
    num_flit_nxt  = num_flit_to_transmit;
    send_nxt      = send_message;
    src_done_nxt  = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_nxt     = NUM_SRC'(1) << win_idx;
          grant_idx_nxt = win_idx;
          num_flit_nxt  = win_flits;
          rr_ptr_nxt    = win_idx;
          // A zero-flit message never gets tx_gone, so it completes without sending.
          if (win_flits == '0) begin
            state_nxt    = DONE;
            src_done_nxt = NUM_SRC'(1) << win_idx;
          end else begin
            state_nxt = SEND;
            send_nxt  = 1'b1;
          end
        end
      end
      SEND: begin
        if (tx_gone && last_clock_beat) begin
          state_nxt    = DONE;
          send_nxt     = 1'b0;
          src_done_nxt = grant;
        end
      end
      DONE: begin
        state_nxt     = IDLE;
        grant_nxt     = '0;
        grant_idx_nxt = '0;
        num_flit_nxt  = '0;
        send_nxt      = 1'b0;
      end
      default: begin
        state_nxt     = IDLE;
        grant_nxt     = '0;
        grant_idx_nxt = '0;
        num_flit_nxt  = '0;
        send_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      rr_ptr               <= SRC_IDX_WD'(NUM_SRC - 1);
      grant                <= '0;
      grant_idx            <= '0;
      num_flit_to_transmit <= '0;
      send_message         <= 1'b0;
      src_done             <= '0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_nxt;
      rr_ptr               <= rr_ptr_nxt;
      grant                <= grant_nxt;
      grant_idx            <= grant_idx_nxt;
      num_flit_to_transmit <= num_flit_nxt;
      send_message         <= send_nxt;
      src_done             <= src_done_nxt;
      busy                 <= (state_nxt != IDLE);
    end
  end

endmodule
